video_out_sync: RTL and testbench
=================================

Name: video_out_sync

Overview:
- Output timing generator and final pixel stage, directly downstream of the horizontal magnifier (video_out_hmag).
- Produces the free-running h_cnt that drives the magnifier's read side, plus v_cnt, hsync, vsync and de for the LCD/HDMI encoder.
- Phase-locks its counters to the VDP frame start.
- Delays sync/de to match the magnifier's RGB pipeline latency, then registers and blanks the RGB.

Parameters:
- H_TOTAL, 1368, clocks per line (h_cnt wraps at H_TOTAL-1)
- V_TOTAL, 524, lines per frame
- H_SYNC_WIDTH, 100, hsync low for h_cnt 0..H_SYNC_WIDTH-1
- H_ACTIVE_START, 200, first active h_cnt
- H_ACTIVE_WIDTH, 1120, active clocks per line
- V_SYNC_WIDTH, 3, vsync low for v_cnt 0..V_SYNC_WIDTH-1
- V_ACTIVE_START, 34, first active line
- V_ACTIVE_HEIGHT, 480, active lines
- H_LOCK_OFFSET, 0, h_cnt value loaded on a frame-start pulse
- PIPE_LATENCY, 3, clocks from h_cnt presented to hmag until its matching RGB arrives (1..7)

Ports:
- clk  in  1  42.95454 MHz system clock
- reset_n  in  1  synchronous, active-low reset
- vdp_frame_start  in  1  one-clock pulse: VDP hcounter=0 and vcounter=0 with enable high
- in_r  in  8  red from video_out_hmag
- in_g  in  8  green from video_out_hmag
- in_b  in  8  blue from video_out_hmag
- reg_scanline  in  1  scanline effect request (used only with the optional feature)
- h_cnt  out  11  horizontal counter to video_out_hmag
- v_cnt  out  10  vertical counter
- locked  out  1  counters in phase with the VDP
- out_hs  out  1  hsync, active low
- out_vs  out  1  vsync, active low
- out_de  out  1  data enable
- out_r  out  8  red to the encoder
- out_g  out  8  green to the encoder
- out_b  out  8  blue to the encoder

Behaviour:
- Clocking: all state updates on posedge clk; synchronous reset on reset_n low.
- Reset values:
  - h_cnt=0, v_cnt=0, locked=0
  - out_hs=1, out_vs=1, out_de=0, out_r/g/b=0
  - delay pipeline cleared to hs=1, vs=1, de=0
- Counters:
  - h_cnt increments each clock; at H_TOTAL-1 it wraps to 0 and v_cnt advances.
  - v_cnt wraps to 0 after V_TOTAL-1.
- Frame lock, evaluated in the cycle vdp_frame_start=1:
  - If h_cnt==H_LOCK_OFFSET and v_cnt==0: counters advance normally and locked<=1.
  - Otherwise: h_cnt<=H_LOCK_OFFSET+1 (mod H_TOTAL), v_cnt<=0, locked<=0.
  - The pulse has priority over the normal wrap in the same cycle.
- Loss of lock: if v_cnt wraps to 0 and no frame-start pulse has arrived since the previous wrap, locked<=0.
- Raw timing, combinational on the counters:
  - hs_raw=(h_cnt>=H_SYNC_WIDTH)
  - vs_raw=(v_cnt>=V_SYNC_WIDTH)
  - de_raw=h_cnt in [H_ACTIVE_START, H_ACTIVE_START+H_ACTIVE_WIDTH) and v_cnt in [V_ACTIVE_START, V_ACTIVE_START+V_ACTIVE_HEIGHT)
- Delay line: hs_raw, vs_raw, de_raw and line parity v_cnt[0] pass through a PIPE_LATENCY-deep shift register, aligning them with in_r/g/b.
- Output register, one further clock:
  - out_hs, out_vs, out_de <= delayed values.
  - out_r/g/b <= delayed de ? in_* : 0.
  - Total latency from h_cnt to out_*: PIPE_LATENCY+1 clocks.
- Counter widths: arithmetic is unsigned; h_cnt is 11 bits, v_cnt is 10 bits; no overflow beyond H_TOTAL/V_TOTAL.
- Mid-frame reset: everything returns to reset values immediately. locked rises only on the second matching pulse after release.

Optional Feature:
- Macro VIDEO_OUT_SCANLINE_EN.
- Defined: when reg_scanline=1 and delayed line parity=1, out_* = in_* - (in_* >> 2), i.e. 75% brightness, 8-bit, floor. Even lines are unchanged. reg_scanline is sampled with the line-parity pipeline stage.
- Undefined: reg_scanline is ignored and RGB passes through unchanged.
- The port list is identical in both builds.

Test Plan:
1. Reset release with no frame pulses -> h_cnt counts 0..1367 and wraps; v_cnt increments at each wrap; locked stays 0; out_de first rises at h_cnt=204 of line 34 (PIPE_LATENCY=3).
2. Pulse at h_cnt=500, v_cnt=10 -> next cycle h_cnt=1, v_cnt=0, locked=0; pulse exactly 1368*524 clocks later -> locked=1.
3. While locked, suppress one frame pulse -> locked falls at the next v_cnt wrap; pulses resumed in phase -> locked=1 again after one frame.
4. in_r/g/b=8'hFF constant -> out_r=8'hFF only while out_de=1, 0 elsewhere; out_hs low for exactly 100 clocks per line; out_vs low for exactly 3 lines.
5. Assert reset_n=0 for 2 clocks mid-frame at v_cnt=200 -> all outputs at reset values on the next edge; counters restart from 0.
6. VIDEO_OUT_SCANLINE_EN defined, reg_scanline=1, in=8'hFF -> even active lines out=8'hFF, odd active lines out=8'hC0; reg_scanline=0 -> all lines 8'hFF.

Source files
------------

// File: rtl/video_out_sync.sv
// video_out_sync: output timing generator (h_cnt/v_cnt locked to vdp_frame_start) plus sync/de delay and RGB blanking stage; ports clk, reset_n, vdp_frame_start, in_r/g/b, reg_scanline -> h_cnt, v_cnt, locked, out_hs/vs/de, out_r/g/b; `define VIDEO_OUT_SCANLINE_EN dims odd lines to 75% when reg_scanline=1
module video_out_sync #(
  parameter int H_TOTAL         = 1368,
  parameter int V_TOTAL         = 524,
  parameter int H_SYNC_WIDTH    = 100,
  parameter int H_ACTIVE_START  = 200,
  parameter int H_ACTIVE_WIDTH  = 1120,
  parameter int V_SYNC_WIDTH    = 3,
  parameter int V_ACTIVE_START  = 34,
  parameter int V_ACTIVE_HEIGHT = 480,
  parameter int H_LOCK_OFFSET   = 0,
  parameter int PIPE_LATENCY    = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vdp_frame_start,
  input  logic [7:0]  in_r,
  input  logic [7:0]  in_g,
  input  logic [7:0]  in_b,
  input  logic        reg_scanline,
  output logic [10:0] h_cnt,
  output logic [9:0]  v_cnt,
  output logic        locked,
  output logic        out_hs,
  output logic        out_vs,
  output logic        out_de,
  output logic [7:0]  out_r,
  output logic [7:0]  out_g,
  output logic [7:0]  out_b
);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_LOCK   = 11'(H_LOCK_OFFSET);
  localparam logic [10:0] H_RESYNC = 11'((H_LOCK_OFFSET + 1) % H_TOTAL);
  localparam logic [10:0] HS_W     = 11'(H_SYNC_WIDTH);
  localparam logic [10:0] HA_S     = 11'(H_ACTIVE_START);
  localparam logic [10:0] HA_E     = 11'(H_ACTIVE_START + H_ACTIVE_WIDTH);
  localparam logic [9:0]  VS_W     = 10'(V_SYNC_WIDTH);
  localparam logic [9:0]  VA_S     = 10'(V_ACTIVE_START);
  localparam logic [9:0]  VA_E     = 10'(V_ACTIVE_START + V_ACTIVE_HEIGHT);
  logic       armed, seen, h_wrap, v_wrap, match, resync;
  logic       hs_raw, vs_raw, de_raw, dim;
  logic [3:0] dly [PIPE_LATENCY];
  logic [3:0] tap;
  always_comb begin
    h_wrap = h_cnt == H_LAST;
    v_wrap = h_wrap && v_cnt == V_LAST;
    match  = h_cnt == H_LOCK && v_cnt == '0;
    resync = vdp_frame_start && !match;
    hs_raw = h_cnt >= HS_W;
    vs_raw = v_cnt >= VS_W;
    de_raw = h_cnt >= HA_S && h_cnt < HA_E && v_cnt >= VA_S && v_cnt < VA_E;
    tap    = dly[PIPE_LATENCY-1];
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      h_cnt  <= '0;
      v_cnt  <= '0;
      locked <= 1'b0;
      armed  <= 1'b0;
      seen   <= 1'b0;
    end else begin
      h_cnt  <= resync ? H_RESYNC : h_wrap ? '0 : h_cnt + 11'd1;
      v_cnt  <= resync ? '0 : !h_wrap ? v_cnt : v_wrap ? '0 : v_cnt + 10'd1;
      locked <= vdp_frame_start ? match && armed : (v_wrap && !seen) ? 1'b0 : locked;
      armed  <= armed | vdp_frame_start;
      seen   <= vdp_frame_start | (seen & !v_wrap);
    end
  always_ff @(posedge clk)
    if (!reset_n) begin
      for (int i = 0; i < PIPE_LATENCY; i++) dly[i] <= 4'b1100;
    end else begin
      dly[0] <= {hs_raw, vs_raw, de_raw, v_cnt[0] & reg_scanline};
      for (int i = 1; i < PIPE_LATENCY; i++) dly[i] <= dly[i-1];
    end
`ifdef VIDEO_OUT_SCANLINE_EN
  assign dim = tap[0];
`else
  logic unused_dim;
  assign unused_dim = tap[0];
  assign dim = 1'b0;
`endif
  function automatic logic [7:0] px(input logic [7:0] c, input logic de, input logic dm);
    return !de ? 8'd0 : dm ? c - (c >> 2) : c;
  endfunction
  always_ff @(posedge clk)
    if (!reset_n) begin
      out_hs <= 1'b1;
      out_vs <= 1'b1;
      out_de <= 1'b0;
      out_r  <= '0;
      out_g  <= '0;
      out_b  <= '0;
    end else begin
      out_hs <= tap[3];
      out_vs <= tap[2];
      out_de <= tap[1];
      out_r  <= px(in_r, tap[1], dim);
      out_g  <= px(in_g, tap[1], dim);
      out_b  <= px(in_b, tap[1], dim);
    end
endmodule

// File: tb/tb_video_out_sync.sv
// tb_video_out_sync: directed checks of video_out_sync on a shrunken 40x20 raster
module tb_video_out_sync;
  logic        clk = 1'b0;
  logic        reset_n, vdp_frame_start, reg_scanline;
  logic [7:0]  in_r, in_g, in_b, out_r, out_g, out_b;
  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic        locked, out_hs, out_vs, out_de;
  int          vecs = 0, errs = 0;
  int          hs_lo, vs_lo, de_hi, bad;
`ifdef VIDEO_OUT_SCANLINE_EN
  localparam logic [7:0] ODD_FF = 8'hC0;
`else
  localparam logic [7:0] ODD_FF = 8'hFF;
`endif
  video_out_sync #(
    .H_TOTAL(40), .V_TOTAL(20), .H_SYNC_WIDTH(4), .H_ACTIVE_START(8), .H_ACTIVE_WIDTH(24),
    .V_SYNC_WIDTH(3), .V_ACTIVE_START(5), .V_ACTIVE_HEIGHT(10), .H_LOCK_OFFSET(0), .PIPE_LATENCY(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .vdp_frame_start(vdp_frame_start),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .reg_scanline(reg_scanline),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .locked(locked),
    .out_hs(out_hs), .out_vs(out_vs), .out_de(out_de),
    .out_r(out_r), .out_g(out_g), .out_b(out_b)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_rst(input string tag);
    chk({tag, "_h"}, 32'(h_cnt), 0);
    chk({tag, "_v"}, 32'(v_cnt), 0);
    chk({tag, "_lock"}, 32'(locked), 0);
    chk({tag, "_hs"}, 32'(out_hs), 1);
    chk({tag, "_vs"}, 32'(out_vs), 1);
    chk({tag, "_de"}, 32'(out_de), 0);
    chk({tag, "_r"}, 32'(out_r), 0);
    chk({tag, "_g"}, 32'(out_g), 0);
    chk({tag, "_b"}, 32'(out_b), 0);
  endtask
  initial begin
    reset_n = 1'b0; vdp_frame_start = 1'b0; reg_scanline = 1'b0;
    in_r = 8'hFF; in_g = 8'hFF; in_b = 8'hFF;
    tick(3);
    chk_rst("por");
    reset_n = 1'b1;
    tick(1);   chk("h_n1", 32'(h_cnt), 1);   chk("v_n1", 32'(v_cnt), 0);
    tick(38);  chk("h_n39", 32'(h_cnt), 39); chk("v_n39", 32'(v_cnt), 0);
    tick(1);   chk("h_wrap", 32'(h_cnt), 0); chk("v_inc", 32'(v_cnt), 1);
    tick(171); chk("h_n211", 32'(h_cnt), 11); chk("v_n211", 32'(v_cnt), 5);
    chk("de_pre", 32'(out_de), 0); chk("r_pre", 32'(out_r), 0);
    tick(1);   chk("de_first", 32'(out_de), 1); chk("r_first", 32'(out_r), 8'hFF);
    hs_lo = 0; de_hi = 0; bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (!out_hs) hs_lo++;
      if (out_de) de_hi++;
      if (out_r !== (out_de ? 8'hFF : 8'h00)) bad++;
    end
    chk("hs_line", 32'(hs_lo), 4); chk("de_line", 32'(de_hi), 24); chk("rgb_blank_line", 32'(bad), 0);
    hs_lo = 0; vs_lo = 0; de_hi = 0; bad = 0;
    for (int i = 0; i < 800; i++) begin
      tick(1);
      if (!out_hs) hs_lo++;
      if (!out_vs) vs_lo++;
      if (out_de) de_hi++;
      if (out_r !== (out_de ? 8'hFF : 8'h00)) bad++;
    end
    chk("hs_frame", 32'(hs_lo), 80); chk("vs_frame", 32'(vs_lo), 120);
    chk("de_frame", 32'(de_hi), 240); chk("rgb_blank_frame", 32'(bad), 0);
    chk("h_n1052", 32'(h_cnt), 12); chk("v_n1052", 32'(v_cnt), 6); chk("lock_free", 32'(locked), 0);
    vdp_frame_start = 1'b1; tick(1); vdp_frame_start = 1'b0;
    chk("h_resync", 32'(h_cnt), 1); chk("v_resync", 32'(v_cnt), 0); chk("lock_resync", 32'(locked), 0);
    tick(799);
    chk("h_frame1", 32'(h_cnt), 0); chk("v_frame1", 32'(v_cnt), 0); chk("lock_pre", 32'(locked), 0);
    vdp_frame_start = 1'b1; tick(1); vdp_frame_start = 1'b0;
    chk("lock_rise", 32'(locked), 1); chk("h_locked", 32'(h_cnt), 1);
    tick(799); vdp_frame_start = 1'b1; tick(1); vdp_frame_start = 1'b0;
    chk("lock_hold", 32'(locked), 1);
    tick(1598); chk("lock_missed_pulse", 32'(locked), 1);
    tick(1);
    chk("lock_lost", 32'(locked), 0); chk("h_lost", 32'(h_cnt), 0); chk("v_lost", 32'(v_cnt), 0);
    vdp_frame_start = 1'b1; tick(1); vdp_frame_start = 1'b0;
    chk("lock_regain", 32'(locked), 1);
    reg_scanline = 1'b1;
    tick(219);
    chk("h_l5", 32'(h_cnt), 20); chk("v_l5", 32'(v_cnt), 5);
    chk("scan_odd_r", 32'(out_r), ODD_FF); chk("scan_odd_g", 32'(out_g), ODD_FF); chk("scan_odd_b", 32'(out_b), ODD_FF);
    tick(40);  chk("scan_even_r", 32'(out_r), 8'hFF);
    reg_scanline = 1'b0;
    tick(40);  chk("scan_off_odd_r", 32'(out_r), 8'hFF);
    in_r = 8'h5A; in_g = 8'h3C; in_b = 8'hA5;
    tick(40);
    chk("pass_r", 32'(out_r), 8'h5A); chk("pass_g", 32'(out_g), 8'h3C); chk("pass_b", 32'(out_b), 8'hA5);
    tick(15);  chk("de_last_col", 32'(out_de), 1);
    tick(1);   chk("de_after_col", 32'(out_de), 0); chk("r_after_col", 32'(out_r), 0);
    tick(224);
    chk("v_l14", 32'(v_cnt), 14); chk("de_last_line", 32'(out_de), 1);
    chk("r_last_line", 32'(out_r), 8'h5A); chk("lock_before_rst", 32'(locked), 1);
    reset_n = 1'b0;
    tick(1);   chk_rst("mid");
    tick(1);
    reset_n = 1'b1; vdp_frame_start = 1'b1; tick(1); vdp_frame_start = 1'b0;
    chk("h_rel", 32'(h_cnt), 1); chk("lock_first_match", 32'(locked), 0);
    tick(799);
    chk("h_rel_frame", 32'(h_cnt), 0); chk("v_rel_frame", 32'(v_cnt), 0);
    vdp_frame_start = 1'b1; tick(1); vdp_frame_start = 1'b0;
    chk("lock_second_match", 32'(locked), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
